// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the shared RAM and mem_arbiter.
// The arbiter takes the slave view; the requesters and RAM take the master view.
interface mem_arbiter_if;
    logic [1:0]  cpu_cmd;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_grant;
    logic        cpu_rvalid;
    logic [1:0]  dma_cmd;
    logic [8:0]  dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_grant;
    logic        dma_rvalid;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_cmd, cpu_addr, cpu_wdata,
        input  dma_cmd, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_grant, cpu_rvalid, dma_grant, dma_rvalid,
        output mem_cmd, mem_addr, mem_wdata
    );

    modport master (
        output cpu_cmd, cpu_addr, cpu_wdata,
        output dma_cmd, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_grant, cpu_rvalid, dma_grant, dma_rvalid,
        input  mem_cmd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for a single shared RAM with bounded hold and preemption.
// Optional MEM_ARB_RR_EN: round-robin tie-break in IDLE; otherwise ties go to the CPU.
module mem_arbiter #(
    parameter int MAX_HOLD = 8    // legal range 2..15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_CPU = 2'b01,
        OWN_DMA = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  hold_cnt_r;
    logic        last_owner_r;    // 1'b1 = DMA, 1'b0 = CPU
    logic        cpu_req_s;
    logic        dma_req_s;
    logic        tie_cpu_s;
    logic        cpu_rvalid_r;
    logic        dma_rvalid_r;
    logic [1:0]  mem_cmd_s;
    logic [8:0]  mem_addr_s;
    logic [15:0] mem_wdata_s;

    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

    // Encoding 2'b11 is never allowed onto the RAM command bus.
    function automatic logic [1:0] clean_cmd(input logic [1:0] cmd);
        return (cmd == 2'b11) ? MNONE : cmd;
    endfunction

    assign cpu_req_s = is_req(bus.cpu_cmd);
    assign dma_req_s = is_req(bus.dma_cmd);

    // Tie-break selection for simultaneous requests seen in IDLE.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        tie_cpu_s = last_owner_r;
`else
        tie_cpu_s = 1'b1;
`endif
    end

    // Next-state logic: grant, hand over without bubble, or preempt at hold limit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req_s && dma_req_s) begin
                    state_next_s = tie_cpu_s ? OWN_CPU : OWN_DMA;
                end else if (cpu_req_s) begin
                    state_next_s = OWN_CPU;
                end else if (dma_req_s) begin
                    state_next_s = OWN_DMA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OWN_CPU: begin
                if (!cpu_req_s) begin
                    state_next_s = dma_req_s ? OWN_DMA : IDLE;
                end else if (dma_req_s && (hold_cnt_r == HOLD_LAST)) begin
                    state_next_s = OWN_DMA;
                end else begin
                    state_next_s = OWN_CPU;
                end
            end
            OWN_DMA: begin
                if (!dma_req_s) begin
                    state_next_s = cpu_req_s ? OWN_CPU : IDLE;
                end else if (cpu_req_s && (hold_cnt_r == HOLD_LAST)) begin
                    state_next_s = OWN_CPU;
                end else begin
                    state_next_s = OWN_DMA;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // RAM-side mux driven from the registered owner; the loser never reaches the RAM.
    always_comb begin
        mem_cmd_s   = MNONE;
        mem_addr_s  = 9'h000;
        mem_wdata_s = 16'h0000;
        case (state_r)
            OWN_CPU: begin
                mem_cmd_s   = clean_cmd(bus.cpu_cmd);
                mem_addr_s  = bus.cpu_addr;
                mem_wdata_s = bus.cpu_wdata;
            end
            OWN_DMA: begin
                mem_cmd_s   = clean_cmd(bus.dma_cmd);
                mem_addr_s  = bus.dma_addr;
                mem_wdata_s = bus.dma_wdata;
            end
            default: begin
                mem_cmd_s   = MNONE;
                mem_addr_s  = 9'h000;
                mem_wdata_s = 16'h0000;
            end
        endcase
    end

    // State, hold counter, last owner and read-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            hold_cnt_r   <= 4'h0;
            last_owner_r <= 1'b1;
            cpu_rvalid_r <= 1'b0;
            dma_rvalid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) && (state_next_s != IDLE)) begin
                hold_cnt_r   <= 4'h0;
                last_owner_r <= (state_next_s == OWN_DMA);
            end else begin
                last_owner_r <= last_owner_r;
                if ((state_r != IDLE) && (hold_cnt_r != 4'hF)) begin
                    hold_cnt_r <= hold_cnt_r + 4'h1;
                end else begin
                    hold_cnt_r <= hold_cnt_r;
                end
            end
            // A read in the final owned cycle still reports, even after handover.
            cpu_rvalid_r <= (state_r == OWN_CPU) && (mem_cmd_s == MREAD);
            dma_rvalid_r <= (state_r == OWN_DMA) && (mem_cmd_s == MREAD);
        end
    end

    assign bus.cpu_grant  = (state_r == OWN_CPU);
    assign bus.dma_grant  = (state_r == OWN_DMA);
    assign bus.cpu_rvalid = cpu_rvalid_r;
    assign bus.dma_rvalid = dma_rvalid_r;
    assign bus.mem_cmd    = mem_cmd_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;
    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    typedef struct {
        logic [3:0]  flags;   // {cpu_grant, dma_grant, cpu_rvalid, dma_rvalid}
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("cpu_grant",  {15'h0, bus.cpu_grant},  {15'h0, e.flags[3]});
            cmp("dma_grant",  {15'h0, bus.dma_grant},  {15'h0, e.flags[2]});
            cmp("cpu_rvalid", {15'h0, bus.cpu_rvalid}, {15'h0, e.flags[1]});
            cmp("dma_rvalid", {15'h0, bus.dma_rvalid}, {15'h0, e.flags[0]});
            cmp("mem_cmd",    {14'h0, bus.mem_cmd},    {14'h0, e.cmd});
            cmp("mem_addr",   {7'h0,  bus.mem_addr},   {7'h0,  e.addr});
            cmp("mem_wdata",  bus.mem_wdata,           e.wdata);
        end
    end

    task automatic step(input logic rst,
                        input logic [1:0] cc, input logic [8:0] ca, input logic [15:0] cw,
                        input logic [1:0] dc, input logic [8:0] da, input logic [15:0] dw,
                        input logic chk, input logic [3:0] flags,
                        input logic [1:0] ecmd, input logic [8:0] eaddr, input logic [15:0] ewd);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.cpu_cmd   = cc;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cw;
        bus.dma_cmd   = dc;
        bus.dma_addr  = da;
        bus.dma_wdata = dw;
        if (chk) begin
            e.flags = flags;
            e.cmd   = ecmd;
            e.addr  = eaddr;
            e.wdata = ewd;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.cpu_cmd   = N;
        bus.cpu_addr  = 9'h000;
        bus.cpu_wdata = 16'h0000;
        bus.dma_cmd   = N;
        bus.dma_addr  = 9'h000;
        bus.dma_wdata = 16'h0000;
        bus.mem_rdata = 16'h0000;

        // Reset state, then single CPU read with one-cycle grant and rvalid latency.
        step(1'b1, N, 9'h000, 16'h0000, N, 9'h000, 16'h0000, 1'b0, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b1, N, 9'h000, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, R, 9'h005, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, R, 9'h005, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b1000, R, 9'h005, 16'h0000);
        step(1'b0, N, 9'h005, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b1010, N, 9'h005, 16'h0000);
        step(1'b0, N, 9'h005, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b0000, N, 9'h000, 16'h0000);

        // Fresh reset, then two simultaneous-request rounds to exercise the tie-break.
        step(1'b1, N, 9'h005, 16'h0000, N, 9'h000, 16'h0000, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, W, 9'h010, 16'h1111, W, 9'h020, 16'h2222, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, W, 9'h010, 16'h1111, W, 9'h020, 16'h2222, 1'b1, 4'b1000, W, 9'h010, 16'h1111);
        step(1'b0, N, 9'h010, 16'h1111, N, 9'h020, 16'h2222, 1'b1, 4'b1000, N, 9'h010, 16'h1111);
        step(1'b0, R, 9'h011, 16'h1111, R, 9'h021, 16'h2222, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
`ifdef MEM_ARB_RR_EN
        step(1'b0, R, 9'h011, 16'h1111, R, 9'h021, 16'h2222, 1'b1, 4'b0100, R, 9'h021, 16'h2222);
        step(1'b0, N, 9'h011, 16'h1111, N, 9'h021, 16'h2222, 1'b1, 4'b0101, N, 9'h021, 16'h2222);
`else
        step(1'b0, R, 9'h011, 16'h1111, R, 9'h021, 16'h2222, 1'b1, 4'b1000, R, 9'h011, 16'h1111);
        step(1'b0, N, 9'h011, 16'h1111, N, 9'h021, 16'h2222, 1'b1, 4'b1010, N, 9'h011, 16'h1111);
`endif

        // CPU streams reads, DMA joins: 8 CPU cycles, direct handover, then CPU back.
        step(1'b0, R, 9'h030, 16'h0000, N, 9'h021, 16'h2222, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, R, 9'h030, 16'h0000, R, 9'h040, 16'h0000, 1'b1, 4'b1000, R, 9'h030, 16'h0000);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, R, 9'h030, 16'h0000, R, 9'h040, 16'h0000, 1'b1, 4'b1010, R, 9'h030, 16'h0000);
        end
        step(1'b0, R, 9'h030, 16'h0000, R, 9'h040, 16'h0000, 1'b1, 4'b0110, R, 9'h040, 16'h0000);
        step(1'b0, R, 9'h030, 16'h0000, N, 9'h040, 16'h0000, 1'b1, 4'b0101, N, 9'h040, 16'h0000);
        step(1'b0, R, 9'h030, 16'h0000, N, 9'h040, 16'h0000, 1'b1, 4'b1000, R, 9'h030, 16'h0000);

        // CPU releases while DMA writes: DMA granted next cycle with its write forwarded.
        step(1'b0, N, 9'h030, 16'h0000, W, 9'h1FF, 16'hBEEF, 1'b1, 4'b1010, N, 9'h030, 16'h0000);
        step(1'b0, N, 9'h030, 16'h0000, W, 9'h1FF, 16'hBEEF, 1'b1, 4'b0100, W, 9'h1FF, 16'hBEEF);

        // Reset during a DMA read: ownership and pending rvalid are dropped.
        step(1'b1, N, 9'h030, 16'h0000, R, 9'h0AA, 16'hBEEF, 1'b1, 4'b0100, R, 9'h0AA, 16'hBEEF);
        step(1'b0, N, 9'h030, 16'h0000, R, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, N, 9'h030, 16'h0000, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0100, N, 9'h0AA, 16'hBEEF);

        // Command 2'b11 is not a request and is never forwarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, X, 9'h055, 16'h1234, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        end
        step(1'b0, N, 9'h055, 16'h1234, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, W, 9'h100, 16'h5A5A, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, X, 9'h100, 16'h5A5A, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b1000, N, 9'h100, 16'h5A5A);
        step(1'b0, N, 9'h100, 16'h5A5A, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);
        step(1'b0, N, 9'h100, 16'h5A5A, N, 9'h0AA, 16'hBEEF, 1'b1, 4'b0000, N, 9'h000, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
